// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: round-robin issue into a fixed-latency pipeline with id tagging and start/stop/drain control
module pipeline_sequencer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic [WIDTH-1:0] pipe_in,
    input  logic [WIDTH-1:0] pipe_out,
    output logic             res_valid,
    output logic             res_id,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  issued,
    output logic [CNTW-1:0]  completed
);
    localparam int LAT = DEPTH + 1;
    localparam int IW  = $clog2(LAT + 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t         state;
    logic [LAT-1:0] tag_v, tag_id;
    logic [IW-1:0]  inflight;
    logic           last_grant, grant, hs, tail_v;
    always_comb begin
        grant      = (req0_valid && req1_valid) ? !last_grant : req1_valid;
        req0_ready = state == RUN && !stop && !grant;
        req1_ready = state == RUN && !stop && grant;
        hs         = (req0_ready && req0_valid) || (req1_ready && req1_valid);
        pipe_in    = hs ? (grant ? req1_data : req0_data) : '0;
    end
    assign tail_v    = tag_v[LAT-1];
    assign res_valid = tail_v;
    assign res_id    = tag_id[LAT-1];
    assign res_data  = pipe_out;
    assign busy      = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tag_v      <= '0;
            tag_id     <= '0;
            inflight   <= '0;
            last_grant <= 1'b1;
            issued     <= '0;
            completed  <= '0;
            done       <= 1'b0;
        end else begin
            tag_v      <= {tag_v[LAT-2:0], hs};
            tag_id     <= {tag_id[LAT-2:0], hs && grant};
            inflight   <= inflight + IW'(hs) - IW'(tail_v);
            issued     <= issued + CNTW'(hs);
            completed  <= completed + CNTW'(tail_v);
            last_grant <= hs ? grant : last_grant;
            done       <= 1'b0;
            case (state)
                IDLE:    if (start && !stop) state <= RUN;
                RUN:     if (stop) state <= DRAIN;
                // leave once the last in-flight token completes this cycle
                DRAIN:   if (inflight == IW'(tail_v)) begin
                             state <= IDLE;
                             done  <= 1'b1;
                         end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed checks of arbitration, tagging, drain control and counters with DEPTH=2
module tb_pipeline_sequencer;
    logic clk = 0, rst = 0, start = 0, stop = 0;
    logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [7:0] req0_data = 0, req1_data = 0, pipe_in, pipe_out, res_data, s1, s2;
    logic res_valid, res_id, busy, done;
    logic [15:0] issued, completed;
    int vectors = 0, miscompares = 0;
    always #5 clk = ~clk;
    // two +1 stages and a *2 output register: (in+2)*2, no reset so stale data drains
    always_ff @(posedge clk) begin
        s1       <= pipe_in + 8'd1;
        s2       <= s1 + 8'd1;
        pipe_out <= s2 * 8'd2;
    end
    pipeline_sequencer #(.DEPTH(2), .WIDTH(8), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .pipe_in(pipe_in), .pipe_out(pipe_out), .res_valid(res_valid), .res_id(res_id),
        .res_data(res_data), .busy(busy), .done(done), .issued(issued), .completed(completed)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        {start, stop, req0_valid, req1_valid, req0_data, req1_data} = '0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask
    task automatic do_start();
        start = 1;
        tick();
        start = 0;
    endtask
    initial begin
        do_reset();
        #1;
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_id", res_id, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pipe_in", pipe_in, 0);
        check("rst_issued", issued, 0);
        check("rst_completed", completed, 0);
        // single issue, latency 3
        do_start();
        req0_valid = 1;
        req0_data = 0;
        #1;
        check("t1_ready0", req0_ready, 1);
        check("t1_pipe_in", pipe_in, 0);
        tick();
        req0_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            check("t1_res_valid", res_valid, i == 3);
            if (i == 3) begin
                check("t1_res_id", res_id, 0);
                check("t1_res_data", res_data, 4);
            end
            tick();
        end
        stop = 1;
        tick();
        stop = 0;
        check("t1_done_early", done, 0);
        tick();
        check("t1_done", done, 1);
        check("t1_busy", busy, 0);
        check("t1_issued", issued, 1);
        check("t1_completed", completed, 1);
        // alternating grants with both requesters valid
        do_reset();
        do_start();
        for (int i = 0; i < 10; i++) begin
            req0_valid = i < 6;
            req1_valid = i < 6;
            req0_data = 8'(i);
            req1_data = 8'(100 + i);
            #1;
            if (i < 6) begin
                check("t2_ready0", req0_ready, i % 2 == 0);
                check("t2_ready1", req1_ready, i % 2 == 1);
            end
            check("t2_res_valid", res_valid, i >= 3 && i < 9);
            if (i >= 3 && i < 9) begin
                check("t2_res_id", res_id, (i - 3) % 2);
                check("t2_res_data", res_data, ((i - 3) % 2 == 0) ? 2 * (i - 3 + 2) : 2 * (100 + i - 3 + 2) % 256);
            end
            tick();
        end
        check("t2_issued", issued, 6);
        check("t2_completed", completed, 6);
        // req1 alone, then first tie goes to req0
        do_reset();
        do_start();
        for (int i = 0; i < 5; i++) begin
            req1_valid = 1;
            req0_valid = i >= 3;
            #1;
            check("t3_ready0", req0_ready, i == 3);
            check("t3_ready1", req1_ready, i != 3);
            tick();
        end
        // three issues, then stop and drain
        do_reset();
        do_start();
        for (int i = 0; i < 10; i++) begin
            req0_valid = 1;
            req0_data = 8'(i + 1);
            stop = i == 3;
            #1;
            check("t4_ready0", req0_ready, i < 3);
            if (i == 3) check("t4_pipe_in_stop", pipe_in, 0);
            check("t4_done", done, i == 6);
            check("t4_res_valid", res_valid, i >= 3 && i <= 5);
            if (i >= 3 && i <= 5) check("t4_res_data", res_data, 2 * (i - 3 + 1 + 2));
            check("t4_busy", busy, i < 6);
            tick();
        end
        stop = 0;
        req0_valid = 0;
        check("t4_issued", issued, 3);
        check("t4_completed", completed, 3);
        // reset right after an issue clears the tag
        do_reset();
        do_start();
        req0_valid = 1;
        req0_data = 8'd7;
        tick();
        req0_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            check("t5_res_valid", res_valid, 0);
            check("t5_issued", issued, 0);
            check("t5_completed", completed, 0);
            tick();
        end
        // start+stop together and stop alone in IDLE
        do_reset();
        start = 1;
        stop = 1;
        tick();
        start = 0;
        stop = 0;
        check("t6_busy_both", busy, 0);
        tick();
        check("t6_busy_after", busy, 0);
        stop = 1;
        tick();
        stop = 0;
        for (int i = 0; i < 3; i++) begin
            check("t6_done", done, 0);
            check("t6_busy", busy, 0);
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
